// File: rtl/core_if_prefetch_pkg.sv
// Shared constants for the instruction-fetch path.
//   INST_ADDR_BUS_W / INST_BYTE_BUS_W : default fetch address / instruction widths
//   NOP_INST                          : instruction shown to decode when nothing is valid
//   INST_ALIGN_MASK                   : clears the byte offset inside a 32-bit instruction word
package core_if_prefetch_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;  // InstAddressBus
  localparam int unsigned INST_BYTE_BUS_W = 32;  // InstByteBus

  localparam logic [31:0] NOP_INST        = 32'h0000_0013;
  localparam logic [31:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/core_sync_fifo.sv
// Synchronous FIFO holding {addr, data} fetch entries.
//   clk, rst (sync, active-low)
//   push/wdata : write an entry (accepted when not full, or when full with a same-cycle pop)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop
//   rdata      : head entry, straight from storage
//   full, empty, count
module core_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/core_if_prefetch.sv
// Instruction-fetch unit with a DEPTH-entry prefetch buffer.
// Owns the fetch PC, issues word-aligned requests on a valid/ready bus, pairs
// in-order responses with their addresses and presents the head to decode.
//   clk, rst (sync, active-low)
//   jump_flag_in/jump_addr_in : redirect; flushes the buffer, drops in-flight responses
//   hold_flag_in              : decode stall, head is kept
//   req_valid_out/req_ready_in/req_addr_out : fetch request bus
//   resp_valid_in/resp_data_in              : in-order responses, no backpressure
//   inst_valid_out/inst_out/inst_addr_out   : head entry (NOP / 0 when empty)
//   fifo_count_out                          : buffered entries
module core_if_prefetch
  import core_if_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS_W,
  parameter int unsigned       INST_W   = INST_BYTE_BUS_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_flag_in,
  input  logic [ADDR_W-1:0]        jump_addr_in,
  input  logic                     hold_flag_in,
  output logic                     req_valid_out,
  input  logic                     req_ready_in,
  output logic [ADDR_W-1:0]        req_addr_out,
  input  logic                     resp_valid_in,
  input  logic [INST_W-1:0]        resp_data_in,
  output logic                     inst_valid_out,
  output logic [INST_W-1:0]        inst_out,
  output logic [ADDR_W-1:0]        inst_addr_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              redir_q, redir_d;
  logic              req_valid_q, req_valid_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              fire, unfired, resp_drop;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, push_ok;
  logic [CNT_W-1:0]  fifo_count, cnt_next;
  logic [CNT_W:0]    credit_sum;
  logic [ENT_W-1:0]  fifo_rdata;
  logic [ADDR_W-1:0] jump_aligned;

  assign jump_aligned = jump_addr_in & ~ADDR_W'(~INST_ALIGN_MASK);
  assign fire         = req_valid_q & req_ready_in;
  assign unfired      = req_valid_q & ~req_ready_in;
  assign resp_drop    = resp_valid_in & (drop_q != '0);
  assign fifo_push    = resp_valid_in & ~resp_drop & ~jump_flag_in;
  assign fifo_pop     = ~fifo_empty & ~hold_flag_in;
  assign push_ok      = fifo_push & (~fifo_full | fifo_pop);

  core_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (jump_flag_in),
    .wdata ({resp_pc_q, resp_data_in}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    redirect_pc_d = redirect_pc_q;
    redir_d       = redir_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(resp_valid_in);

    if (fire) begin
      if (redir_q) begin
        // The request held across an earlier jump has just gone out: it is
        // stale, so its response must be dropped, and fetch resumes at the target.
        fetch_pc_d = redirect_pc_q;
        redir_d    = 1'b0;
        drop_d     = drop_d + CNT_W'(1);
      end else begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
    end
    if (resp_drop) drop_d = drop_d - CNT_W'(1);
    if (fifo_push) resp_pc_d = resp_pc_q + ADDR_W'(4);

    if (jump_flag_in) begin
      // Everything accepted so far is stale; a still-pending request is not
      // counted here and is charged to drop_cnt when it finally fires.
      drop_d    = outstanding_d;
      resp_pc_d = jump_aligned;
      if (unfired) begin
        redir_d       = 1'b1;
        redirect_pc_d = jump_aligned;
        fetch_pc_d    = fetch_pc_q;
      end else begin
        redir_d    = 1'b0;
        fetch_pc_d = jump_aligned;
      end
    end

    cnt_next    = jump_flag_in ? '0 : fifo_count + CNT_W'(push_ok) - CNT_W'(fifo_pop);
    credit_sum  = {1'b0, cnt_next} + {1'b0, outstanding_d};
    req_valid_d = unfired | (credit_sum < (CNT_W+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      redir_q       <= 1'b0;
      req_valid_q   <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      redirect_pc_q <= redirect_pc_d;
      redir_q       <= redir_d;
      req_valid_q   <= req_valid_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign req_valid_out  = req_valid_q;
  assign req_addr_out   = fetch_pc_q;
  assign inst_valid_out = ~fifo_empty;
  assign inst_out       = fifo_empty ? INST_W'(NOP_INST) : fifo_rdata[INST_W-1:0];
  assign inst_addr_out  = fifo_empty ? '0 : fifo_rdata[ENT_W-1:INST_W];
  assign fifo_count_out = fifo_count;

endmodule
